reaction_control: RTL and testbench
===================================

Name: reaction_control

Overview:
- Control FSM for the reaction-time game; the sequencing side of the reaction datapath.
- Drives the datapath strobes that start the random-delay countdown, restart the ms up-counter and load the score.
- Consumes the datapath's countComplete and upCount, plus two user buttons.
- Selects the display screen and flags timeout and false start.

Parameters:
HOLD_CYCLES, 50000, clk cycles each start strobe is held high so the 1 kHz datapath counters capture it (>=1 ms at 50 MHz)
TIMEOUT_MS, 4000, upCount value at or above which a round is abandoned as timed out

Ports:
clk  in  1  system clock, 50 MHz
iReset  in  1  asynchronous, active-low reset
iStart  in  1  start button, asynchronous level, active-high
iReact  in  1  reaction button, asynchronous level, active-high
countComplete  in  1  datapath: random delay expired (level)
iUpCount  in  12  datapath: elapsed ms since up-counter restart
oStart_down_count  out  1  datapath: reload random delay
oStart_up_count  out  1  datapath: clear ms up-counter
oLoad_score  out  1  datapath: capture score (rising edge used)
oScreen  out  2  0 prompt, 1 wait, 2 go, 3 result
oTimeout  out  1  last round timed out
oFalseStart  out  1  last round false-started (0 unless FALSE_START_EN)
oState  out  4  current FSM state code, debug

Behaviour:
- Reset (iReset low, async): state IDLE, all outputs 0, synchronisers and hold counter 0. Takes effect mid-round immediately; no strobe survives reset.
- Button path: each of iStart and iReact has a 2-flop synchroniser plus a prev flop; press = sync2 & ~prev.
  - Press acts on the 3rd rising clk edge after the input rises.
  - A held button produces exactly one press.
- States and codes:
  - IDLE=0: oScreen=0. Start press -> ARM_DELAY.
  - ARM_DELAY=1: oStart_down_count=1 and oScreen=1 for exactly HOLD_CYCLES cycles (hold counter runs 0..HOLD_CYCLES-1) -> WAIT_DELAY. oTimeout and oFalseStart clear on entry.
  - WAIT_DELAY=2: oScreen=1. countComplete==1 -> ARM_COUNT. React press is ignored, except under FALSE_START_EN.
  - ARM_COUNT=3: oStart_up_count=1 and oScreen=2 for exactly HOLD_CYCLES cycles -> MEASURE. A react press here -> LOAD.
  - MEASURE=4: oScreen=2. React press -> LOAD. Otherwise iUpCount>=TIMEOUT_MS -> TIMEOUT. If both occur in the same cycle, the react press wins.
  - LOAD=5: oLoad_score=1 for exactly one cycle, oScreen=3 -> RESULT.
  - RESULT=6: oScreen=3. Start press -> ARM_DELAY.
  - TIMEOUT=7: oScreen=3, oTimeout=1, no score load. Start press -> ARM_DELAY.
  - FALSE=8 (only with FALSE_START_EN): oScreen=3, oFalseStart=1, no score load. Start press -> ARM_DELAY.
- Start presses in ARM_DELAY, WAIT_DELAY, ARM_COUNT, MEASURE and LOAD are ignored. React presses in IDLE, RESULT, TIMEOUT and FALSE are ignored.
- oTimeout and oFalseStart persist until the next ARM_DELAY entry or reset.
- Strobes are registered outputs, decoded from the next state, so they are glitch-free.
- Hold counter width is $clog2(HOLD_CYCLES+1). It clears on every state entry.
- Unused state codes recover to IDLE on the next edge.

Optional Feature:
FALSE_START_EN
- Defined: a react press in WAIT_DELAY -> FALSE. oFalseStart=1, oScreen=3, no oLoad_score pulse.
- Undefined: state FALSE is not built, a react press in WAIT_DELAY is ignored, and oFalseStart is tied 0.

Test Plan:
- HOLD_CYCLES=4, reset then release, 3-cycle iStart pulse -> oStart_down_count high exactly 4 cycles, oScreen 0->1. oState goes 1 then 2.
- In WAIT_DELAY drive countComplete=1 -> oStart_up_count high 4 cycles with oScreen=2. Set iUpCount=250 and press iReact -> oLoad_score single 1-cycle pulse, then oScreen=3.
- In MEASURE ramp iUpCount to 4000 with no react -> TIMEOUT, oTimeout=1, no oLoad_score edge. Next start press -> oTimeout=0 on ARM_DELAY entry.
- In MEASURE, react press synchronised into the same cycle iUpCount reaches 4000 -> LOAD taken, oTimeout stays 0.
- Hold iReact high for 100 cycles in MEASURE -> exactly one oLoad_score pulse. Drop iReset mid-ARM_COUNT -> all outputs 0 within the same cycle, oState=0.
- React press in WAIT_DELAY: with FALSE_START_EN -> oFalseStart=1, oScreen=3, no load. Without it -> stays in WAIT_DELAY, oScreen=1.

Source files
------------

// File: rtl/reaction_control_if.sv
// Strobe/status bundle between the reaction-game controller (master) and its
// timing datapath (slave).
interface reaction_control_if;
    logic        countComplete;
    logic [11:0] iUpCount;
    logic        oStart_down_count;
    logic        oStart_up_count;
    logic        oLoad_score;

    modport master (
        input  countComplete,
        input  iUpCount,
        output oStart_down_count,
        output oStart_up_count,
        output oLoad_score
    );

    modport slave (
        output countComplete,
        output iUpCount,
        input  oStart_down_count,
        input  oStart_up_count,
        input  oLoad_score
    );
endinterface

// File: rtl/reaction_control.sv
// Reaction-time game sequencer: synchronises the buttons, walks the round FSM and
// issues held datapath strobes. Optional macro FALSE_START_EN adds the FALSE state.
module reaction_control #(
    parameter int HOLD_CYCLES = 50000,
    parameter int TIMEOUT_MS  = 4000
) (
    input  logic                      clk,
    input  logic                      iReset,
    input  logic                      iStart,
    input  logic                      iReact,
    reaction_control_if.master        dp,
    output logic [1:0]                oScreen,
    output logic                      oTimeout,
    output logic                      oFalseStart,
    output logic [3:0]                oState
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [11:0]   TIMEOUT_VAL = 12'(TIMEOUT_MS);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ARM_DELAY  = 4'd1,
        S_WAIT_DELAY = 4'd2,
        S_ARM_COUNT  = 4'd3,
        S_MEASURE    = 4'd4,
        S_LOAD       = 4'd5,
        S_RESULT     = 4'd6,
        S_TIMEOUT    = 4'd7,
        S_FALSE      = 4'd8
    } state_e;

    state_e        state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          start_s1_q, start_s2_q, start_prev_q;
    logic          react_s1_q, react_s2_q, react_prev_q;
    logic          down_q, down_d, up_q, up_d, load_q, load_d;
    logic [1:0]    screen_q, screen_d;
    logic          timeout_q, timeout_d;
    logic          start_press_s, react_press_s;

    assign start_press_s = start_s2_q & ~start_prev_q;
    assign react_press_s = react_s2_q & ~react_prev_q;

    // Next-state and hold-counter logic; the counter restarts on every state entry.
    always_comb begin
        state_d = state_q;
        hold_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (start_press_s) state_d = S_ARM_DELAY;
                else               state_d = S_IDLE;
            end
            S_ARM_DELAY: begin
                if (hold_q == HOLD_LAST) state_d = S_WAIT_DELAY;
                else                     hold_d  = hold_q + HW'(1);
            end
            S_WAIT_DELAY: begin
                if (dp.countComplete) state_d = S_ARM_COUNT;
`ifdef FALSE_START_EN
                else if (react_press_s) state_d = S_FALSE;
`endif
                else                  state_d = S_WAIT_DELAY;
            end
            S_ARM_COUNT: begin
                if (react_press_s)            state_d = S_LOAD;
                else if (hold_q == HOLD_LAST) state_d = S_MEASURE;
                else                          hold_d  = hold_q + HW'(1);
            end
            S_MEASURE: begin
                // A press landing in the same cycle as the timeout still scores.
                if (react_press_s)                 state_d = S_LOAD;
                else if (dp.iUpCount >= TIMEOUT_VAL) state_d = S_TIMEOUT;
                else                               state_d = S_MEASURE;
            end
            S_LOAD: state_d = S_RESULT;
            S_RESULT, S_TIMEOUT: begin
                if (start_press_s) state_d = S_ARM_DELAY;
                else               state_d = state_q;
            end
`ifdef FALSE_START_EN
            S_FALSE: begin
                if (start_press_s) state_d = S_ARM_DELAY;
                else               state_d = S_FALSE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered strobes line up with it.
    always_comb begin
        down_d   = (state_d == S_ARM_DELAY);
        up_d     = (state_d == S_ARM_COUNT);
        load_d   = (state_d == S_LOAD);
        screen_d = 2'd0;
        case (state_d)
            S_IDLE:                                   screen_d = 2'd0;
            S_ARM_DELAY, S_WAIT_DELAY:                screen_d = 2'd1;
            S_ARM_COUNT, S_MEASURE:                   screen_d = 2'd2;
            S_LOAD, S_RESULT, S_TIMEOUT, S_FALSE:     screen_d = 2'd3;
            default:                                  screen_d = 2'd0;
        endcase
        if (state_d == S_TIMEOUT)        timeout_d = 1'b1;
        else if (state_d == S_ARM_DELAY) timeout_d = 1'b0;
        else                             timeout_d = timeout_q;
    end

    // State, synchronisers and registered outputs.
    always_ff @(posedge clk or negedge iReset) begin
        if (!iReset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            start_s1_q   <= 1'b0;
            start_s2_q   <= 1'b0;
            start_prev_q <= 1'b0;
            react_s1_q   <= 1'b0;
            react_s2_q   <= 1'b0;
            react_prev_q <= 1'b0;
            down_q       <= 1'b0;
            up_q         <= 1'b0;
            load_q       <= 1'b0;
            screen_q     <= 2'd0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            start_s1_q   <= iStart;
            start_s2_q   <= start_s1_q;
            start_prev_q <= start_s2_q;
            react_s1_q   <= iReact;
            react_s2_q   <= react_s1_q;
            react_prev_q <= react_s2_q;
            down_q       <= down_d;
            up_q         <= up_d;
            load_q       <= load_d;
            screen_q     <= screen_d;
            timeout_q    <= timeout_d;
        end
    end

`ifdef FALSE_START_EN
    logic false_q, false_d;

    // False-start flag: set on FALSE entry, cleared when a new round arms.
    always_comb begin
        if (state_d == S_FALSE)          false_d = 1'b1;
        else if (state_d == S_ARM_DELAY) false_d = 1'b0;
        else                             false_d = false_q;
    end

    // False-start flag register.
    always_ff @(posedge clk or negedge iReset) begin
        if (!iReset) false_q <= 1'b0;
        else         false_q <= false_d;
    end

    assign oFalseStart = false_q;
`else
    assign oFalseStart = 1'b0;
`endif

    assign dp.oStart_down_count = down_q;
    assign dp.oStart_up_count   = up_q;
    assign dp.oLoad_score       = load_q;
    assign oScreen              = screen_q;
    assign oTimeout             = timeout_q;
    assign oState               = state_q;

endmodule

// File: tb/tb_reaction_control.sv
// Directed bench for reaction_control with HOLD_CYCLES=4: a vector table for the
// scoring round plus hand sequences for timeout, races, held buttons and reset.
module tb_reaction_control;

    logic       clk = 1'b0;
    logic       iReset, iStart, iReact;
    logic [1:0] oScreen;
    logic       oTimeout, oFalseStart;
    logic [3:0] oState;
    int         checks = 0;
    int         errors = 0;
    int         load_cnt = 0;
    int         snap;

    reaction_control_if dp();

    reaction_control #(.HOLD_CYCLES(4), .TIMEOUT_MS(4000)) dut (
        .clk(clk), .iReset(iReset), .iStart(iStart), .iReact(iReact), .dp(dp),
        .oScreen(oScreen), .oTimeout(oTimeout), .oFalseStart(oFalseStart), .oState(oState)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dp.oLoad_score === 1'b1) load_cnt++;

    typedef struct {
        logic st, re, cc;
        logic [11:0] up;
        int state, scr, dn, upc, ld, to;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic press_start();
        iStart = 1'b1;
        ticks(3);
        iStart = 1'b0;
    endtask

    task automatic arm_to_measure();
        ticks(4);
        dp.countComplete = 1'b1;
        tick();
        dp.countComplete = 1'b0;
        ticks(4);
    endtask

    initial begin
        iReset = 1'b0; iStart = 1'b0; iReact = 1'b0;
        dp.countComplete = 1'b0; dp.iUpCount = 12'd0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 12'd0,   0, 0, 0, 0, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 12'd0,   0, 0, 0, 0, 0, 0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 12'd0,   1, 1, 1, 0, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 12'd0,   1, 1, 1, 0, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 12'd0,   1, 1, 1, 0, 0, 0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 12'd0,   1, 1, 1, 0, 0, 0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 12'd0,   2, 1, 0, 0, 0, 0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 12'd0,   3, 2, 0, 1, 0, 0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 12'd0,   3, 2, 0, 1, 0, 0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 12'd0,   3, 2, 0, 1, 0, 0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 12'd0,   3, 2, 0, 1, 0, 0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 12'd0,   4, 2, 0, 0, 0, 0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 12'd250, 4, 2, 0, 0, 0, 0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 12'd250, 4, 2, 0, 0, 0, 0};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 12'd250, 5, 3, 0, 0, 1, 0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 12'd250, 6, 3, 0, 0, 0, 0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 12'd250, 6, 3, 0, 0, 0, 0};

        #12;
        check("rst_state", int'(oState), 0);
        check("rst_screen", int'(oScreen), 0);
        check("rst_down", int'(dp.oStart_down_count), 0);
        check("rst_timeout", int'(oTimeout), 0);
        iReset = 1'b1;
        tick();
        check("post_rst_state", int'(oState), 0);

        // Full scoring round, one vector per clock.
        for (int i = 0; i < 17; i++) begin
            iStart = vecs[i].st; iReact = vecs[i].re;
            dp.countComplete = vecs[i].cc; dp.iUpCount = vecs[i].up;
            tick();
            check($sformatf("v%0d_state", i),  int'(oState), vecs[i].state);
            check($sformatf("v%0d_screen", i), int'(oScreen), vecs[i].scr);
            check($sformatf("v%0d_down", i),   int'(dp.oStart_down_count), vecs[i].dn);
            check($sformatf("v%0d_up", i),     int'(dp.oStart_up_count), vecs[i].upc);
            check($sformatf("v%0d_load", i),   int'(dp.oLoad_score), vecs[i].ld);
            check($sformatf("v%0d_to", i),     int'(oTimeout), vecs[i].to);
        end
        iReact = 1'b0;
        check("round_load_cycles", load_cnt, 1);

        // Timeout: ramp the up-counter through the threshold without reacting.
        press_start();
        arm_to_measure();
        check("to_measure", int'(oState), 4);
        snap = load_cnt;
        dp.iUpCount = 12'd3999;
        tick();
        check("to_3999_state", int'(oState), 4);
        dp.iUpCount = 12'd4000;
        tick();
        check("to_state", int'(oState), 7);
        check("to_flag", int'(oTimeout), 1);
        check("to_screen", int'(oScreen), 3);
        dp.iUpCount = 12'd0;
        ticks(3);
        check("to_persist", int'(oTimeout), 1);
        check("to_noload", load_cnt - snap, 0);
        press_start();
        check("to_rearm_state", int'(oState), 1);
        check("to_cleared", int'(oTimeout), 0);

        // React press resolving in the same cycle the timeout threshold is hit.
        arm_to_measure();
        dp.iUpCount = 12'd3999;
        snap = load_cnt;
        iReact = 1'b1;
        ticks(2);
        dp.iUpCount = 12'd4000;
        tick();
        check("race_state", int'(oState), 5);
        check("race_to", int'(oTimeout), 0);
        iReact = 1'b0;
        dp.iUpCount = 12'd0;
        tick();
        check("race_result", int'(oState), 6);
        check("race_load", load_cnt - snap, 1);

        // Held react button yields exactly one load pulse.
        press_start();
        arm_to_measure();
        snap = load_cnt;
        iReact = 1'b1;
        ticks(100);
        check("held_loads", load_cnt - snap, 1);
        check("held_state", int'(oState), 6);
        iReact = 1'b0;
        ticks(2);

        // Asynchronous reset in the middle of ARM_COUNT.
        press_start();
        ticks(4);
        dp.countComplete = 1'b1;
        tick();
        dp.countComplete = 1'b0;
        tick();
        check("pre_rst_up", int'(dp.oStart_up_count), 1);
        iReset = 1'b0;
        #1;
        check("mid_rst_state", int'(oState), 0);
        check("mid_rst_up", int'(dp.oStart_up_count), 0);
        check("mid_rst_screen", int'(oScreen), 0);
        check("mid_rst_load", int'(dp.oLoad_score), 0);
        @(negedge clk);
        iReset = 1'b1;
        ticks(3);
        check("post_mid_rst", int'(oState), 0);

        // React press while waiting for the random delay.
        press_start();
        ticks(4);
        check("fs_wait", int'(oState), 2);
        snap = load_cnt;
        iReact = 1'b1;
        ticks(3);
        iReact = 1'b0;
        tick();
`ifdef FALSE_START_EN
        check("fs_state", int'(oState), 8);
        check("fs_screen", int'(oScreen), 3);
        check("fs_flag", int'(oFalseStart), 1);
`else
        check("fs_state", int'(oState), 2);
        check("fs_screen", int'(oScreen), 1);
        check("fs_flag", int'(oFalseStart), 0);
`endif
        check("fs_noload", load_cnt - snap, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
